// File: rtl/melody_player_param.sv
// melody_player_param: buzzer melody sequencer that plays pitch/beat entries from an external song ROM.
// Optional build macro TEMPO_CTRL_EN adds a tempo input that rescales the beat length of each note.
module melody_player_param #(
  parameter int CLK_HZ   = 48000000,
  parameter int BEAT_CYC = 12000000,
  parameter int SONG_LEN = 148,
  parameter int ADDR_W   = 8,
  parameter int DIV_W    = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
`ifdef TEMPO_CTRL_EN
  input  logic [1:0]        tempo,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              beep,
  output logic              busy,
  output logic [ADDR_W-1:0] note_idx,
  output logic              done
);

`ifdef TEMPO_CTRL_EN
  localparam int DUR_W = $clog2(16 * BEAT_CYC) + 1;
`else
  localparam int DUR_W = $clog2(16 * BEAT_CYC);
`endif

  // Half-period of each pitch in sys_clk cycles, rounded to the nearest cycle.
  localparam logic [DIV_W-1:0] HP_1  = DIV_W'((CLK_HZ + 392)  / (2 * 392));
  localparam logic [DIV_W-1:0] HP_2  = DIV_W'((CLK_HZ + 440)  / (2 * 440));
  localparam logic [DIV_W-1:0] HP_3  = DIV_W'((CLK_HZ + 494)  / (2 * 494));
  localparam logic [DIV_W-1:0] HP_4  = DIV_W'((CLK_HZ + 523)  / (2 * 523));
  localparam logic [DIV_W-1:0] HP_5  = DIV_W'((CLK_HZ + 587)  / (2 * 587));
  localparam logic [DIV_W-1:0] HP_6  = DIV_W'((CLK_HZ + 659)  / (2 * 659));
  localparam logic [DIV_W-1:0] HP_7  = DIV_W'((CLK_HZ + 698)  / (2 * 698));
  localparam logic [DIV_W-1:0] HP_8  = DIV_W'((CLK_HZ + 784)  / (2 * 784));
  localparam logic [DIV_W-1:0] HP_9  = DIV_W'((CLK_HZ + 880)  / (2 * 880));
  localparam logic [DIV_W-1:0] HP_10 = DIV_W'((CLK_HZ + 988)  / (2 * 988));
  localparam logic [DIV_W-1:0] HP_11 = DIV_W'((CLK_HZ + 1047) / (2 * 1047));
  localparam logic [DIV_W-1:0] HP_12 = DIV_W'((CLK_HZ + 1175) / (2 * 1175));
  localparam logic [DIV_W-1:0] HP_13 = DIV_W'((CLK_HZ + 1319) / (2 * 1319));
  localparam logic [DIV_W-1:0] HP_14 = DIV_W'((CLK_HZ + 1568) / (2 * 1568));
  localparam logic [DIV_W-1:0] HP_15 = DIV_W'((CLK_HZ + 1760) / (2 * 1760));

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_END} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [ADDR_W-1:0]  r_romAddr;
  logic [ADDR_W-1:0]  r_noteIdx;
  logic [3:0]         r_pitch;
  logic [DUR_W-1:0]   r_durLast;
  logic [DUR_W-1:0]   r_durCnt;
  logic [DIV_W-1:0]   r_toneCnt;
  logic               r_tone;
  logic               r_done;

  logic [DIV_W-1:0]   w_hp;
  logic [DUR_W-1:0]   w_beats;
  logic [DUR_W-1:0]   w_beatLen;
  logic [DUR_W-1:0]   w_durLastNext;
  logic               w_isEnd;
  logic               w_durEnd;
  logic               w_lastEntry;

  always_comb begin
    w_hp = '0;
    case (r_pitch)
      4'd1:    w_hp = HP_1;
      4'd2:    w_hp = HP_2;
      4'd3:    w_hp = HP_3;
      4'd4:    w_hp = HP_4;
      4'd5:    w_hp = HP_5;
      4'd6:    w_hp = HP_6;
      4'd7:    w_hp = HP_7;
      4'd8:    w_hp = HP_8;
      4'd9:    w_hp = HP_9;
      4'd10:   w_hp = HP_10;
      4'd11:   w_hp = HP_11;
      4'd12:   w_hp = HP_12;
      4'd13:   w_hp = HP_13;
      4'd14:   w_hp = HP_14;
      4'd15:   w_hp = HP_15;
      default: w_hp = '0;
    endcase
  end

`ifdef TEMPO_CTRL_EN
  always_comb begin
    w_beatLen = DUR_W'(BEAT_CYC);
    case (tempo)
      2'd1:    w_beatLen = DUR_W'(BEAT_CYC / 2);
      2'd2:    w_beatLen = DUR_W'(BEAT_CYC * 2);
      default: w_beatLen = DUR_W'(BEAT_CYC);
    endcase
  end
`else
  assign w_beatLen = DUR_W'(BEAT_CYC);
`endif

  // A zero beat field on a real note means a full 16-beat note.
  assign w_beats       = (rom_data[3:0] == 4'd0) ? DUR_W'(16) : DUR_W'(rom_data[3:0]);
  assign w_durLastNext = w_beats * w_beatLen - DUR_W'(1);
  assign w_isEnd       = (rom_data == 8'h00);
  assign w_durEnd      = (r_durCnt == r_durLast) && !pause;
  assign w_lastEntry   = (r_romAddr == ADDR_W'(SONG_LEN - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nextState = S_FETCH;
      S_FETCH: w_nextState = S_LOAD;
      S_LOAD:  w_nextState = w_isEnd ? S_END : S_PLAY;
      S_PLAY:  if (w_durEnd) w_nextState = w_lastEntry ? S_END : S_FETCH;
      S_END:   w_nextState = loop_en ? S_FETCH : S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
    if (stop) w_nextState = S_IDLE;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_romAddr <= '0;
      r_noteIdx <= '0;
      r_pitch   <= '0;
      r_durLast <= '0;
      r_durCnt  <= '0;
      r_toneCnt <= '0;
      r_tone    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        r_tone <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (start) r_romAddr <= '0;
          S_LOAD: begin
            if (!w_isEnd) begin
              r_noteIdx <= r_romAddr;
              r_pitch   <= rom_data[7:4];
              r_durLast <= w_durLastNext;
              r_durCnt  <= '0;
              r_toneCnt <= '0;
              r_tone    <= 1'b0;
            end
          end
          // Pause freezes both counters in place so the note resumes where it stopped.
          S_PLAY: begin
            if (!pause) begin
              if (w_durEnd) begin
                if (!w_lastEntry) r_romAddr <= r_romAddr + 1'b1;
              end else begin
                r_durCnt <= r_durCnt + 1'b1;
              end
              if (r_pitch == 4'd0) begin
                r_toneCnt <= '0;
                r_tone    <= 1'b0;
              end else if (r_toneCnt == w_hp - DIV_W'(1)) begin
                r_toneCnt <= '0;
                r_tone    <= ~r_tone;
              end else begin
                r_toneCnt <= r_toneCnt + 1'b1;
              end
            end
          end
          S_END: begin
            if (loop_en) r_romAddr <= '0;
            else         r_done    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign beep     = (r_state == S_PLAY) && !pause && r_tone;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign rom_addr = r_romAddr;
  assign note_idx = r_noteIdx;

endmodule

// File: tb/tb_melody_player_param.sv
// tb_melody_player_param: scoreboard bench; expected output transitions are queued with their cycle and
// a negedge monitor pops and compares each observed change of busy, note_idx, beep and done.
module tb_melody_player_param;
  localparam int CLK_HZ   = 48000;
  localparam int BEAT_CYC = 100;
  localparam int SONG_LEN = 4;
  localparam int ADDR_W   = 8;
  localparam int DIV_W    = 16;

  localparam int K_BUSY = 0;
  localparam int K_IDX  = 1;
  localparam int K_BEEP = 2;
  localparam int K_DONE = 3;

  // One pass of ROM {12,41,02,00}: hp(392Hz)=61, hp(523Hz)=46, cycles counted from the start pulse.
  localparam int T_KIND [8] = '{K_BEEP, K_BEEP, K_BEEP, K_BEEP, K_IDX, K_BEEP, K_BEEP, K_IDX};
  localparam int T_VAL  [8] = '{1, 0, 1, 0, 1, 1, 0, 2};
  localparam int T_REL  [8] = '{64, 125, 186, 203, 205, 251, 297, 307};

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic              clk = 1'b0;
  logic              rstN;
  logic              start, stop, pause, loopEn;
  logic [ADDR_W-1:0] romAddr, noteIdx;
  logic [7:0]        romData;
  logic              beep, busy, done;
  logic [7:0]        rom [256];

  ev_t expQ[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  base = 0;
  int  lastIdx = 0;
  bit  monEn = 1'b0;
  logic       pBusy = 1'b0, pBeep = 1'b0, pDone = 1'b0;
  logic [7:0] pIdx = '0;

  melody_player_param #(
    .CLK_HZ(CLK_HZ), .BEAT_CYC(BEAT_CYC), .SONG_LEN(SONG_LEN), .ADDR_W(ADDR_W), .DIV_W(DIV_W)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rstN), .start(start), .stop(stop), .pause(pause),
    .loop_en(loopEn), .rom_addr(romAddr), .rom_data(romData), .beep(beep), .busy(busy),
    .note_idx(noteIdx), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) romData <= rom[romAddr];

  function automatic string kname(input int kind);
    case (kind)
      K_BUSY:  return "busy";
      K_IDX:   return "note_idx";
      K_BEEP:  return "beep";
      default: return "done";
    endcase
  endfunction

  task automatic compareEv(input int kind, input int val);
    ev_t e;
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpected_%s: got %0d at cycle %0d, required no change", kname(kind), val, cyc - base);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        bad++;
        $display("[TB] FAIL event_%s: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                 kname(e.kind), kname(kind), val, cyc - base, kname(e.kind), e.val, e.cyc - base);
      end
    end
  endtask

  // Monitor: every output change is an event that must match the head of the queue.
  always @(negedge clk) begin
    if (monEn) begin
      if (busy !== pBusy)    compareEv(K_BUSY, int'(busy));
      if (noteIdx !== pIdx)  compareEv(K_IDX, int'(noteIdx));
      if (beep !== pBeep)    compareEv(K_BEEP, int'(beep));
      if (done !== pDone)    compareEv(K_DONE, int'(done));
    end
    pBusy = busy;
    pIdx  = noteIdx;
    pBeep = beep;
    pDone = done;
  end

  task automatic checkOutput(input string name, input int actual, input int required);
    total++;
    if (actual != required) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  task automatic pushEv(input int kind, input int val, input int rel);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = base + rel;
    expQ.push_back(e);
    if (kind == K_IDX) lastIdx = val;
  endtask

  task automatic pushStart();
    pushEv(K_BUSY, 1, 1);
    if (lastIdx != 0) pushEv(K_IDX, 0, 3);
  endtask

  task automatic pushEnd(input int rel);
    pushEv(K_BUSY, 0, rel);
    pushEv(K_DONE, 1, rel);
    pushEv(K_DONE, 0, rel + 1);
  endtask

  // Queues one song pass; events later than the pause point slide by the pause length.
  task automatic pushPass(input int offset, input int limit, input int pauseAt, input int pauseLen);
    bit pauseSeen;
    int rel;
    pauseSeen = (pauseAt == 0);
    for (int i = 0; i < 8; i++) begin
      rel = T_REL[i];
      if (!pauseSeen && rel > pauseAt) begin
        pushEv(K_BEEP, 0, offset + pauseAt);
        pushEv(K_BEEP, 1, offset + pauseAt + pauseLen);
        pauseSeen = 1'b1;
      end
      if (pauseAt != 0 && rel > pauseAt) rel += pauseLen;
      if (rel < limit) pushEv(T_KIND[i], T_VAL[i], offset + rel);
    end
  endtask

  // Drives a one-cycle start/stop pulse; a plain start also marks cycle 0 of the song.
  task automatic applyStimulus(input bit doStart, input bit doStop);
    start = doStart;
    stop  = doStop;
    if (doStart && !doStop) base = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic waitRel(input int n);
    while (cyc < base + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: %0d events outstanding, required 0", name, expQ.size());
      expQ.delete();
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    pause = 1'b0;
    loopEn = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'h12;
    rom[1] = 8'h41;
    rom[2] = 8'h02;
    rom[3] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_beep", int'(beep), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_rom_addr", int'(romAddr), 0);
    checkOutput("reset_note_idx", int'(noteIdx), 0);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    monEn = 1'b1;

    $display("[TB] single pass with end marker");
    applyStimulus(1'b1, 1'b0);
    pushStart();
    pushPass(0, 100000, 0, 0);
    pushEnd(510);
    waitDrain("single_pass");

    $display("[TB] looping pass");
    loopEn = 1'b1;
    applyStimulus(1'b1, 1'b0);
    pushStart();
    pushPass(0, 100000, 0, 0);
    pushEv(K_IDX, 0, 512);
    pushPass(509, 100000, 0, 0);
    pushEnd(1019);
    waitRel(600);
    loopEn = 1'b0;
    waitDrain("loop");

    $display("[TB] song length limit without end marker");
    rom[3] = 8'h11;
    applyStimulus(1'b1, 1'b0);
    pushStart();
    pushPass(0, 100000, 0, 0);
    pushEv(K_IDX, 3, 509);
    pushEv(K_BEEP, 1, 570);
    pushEv(K_BEEP, 0, 609);
    pushEnd(610);
    waitDrain("length_limit");
    rom[3] = 8'h00;

    $display("[TB] pause for 50 cycles in entry 0");
    applyStimulus(1'b1, 1'b0);
    pushStart();
    pushPass(0, 100000, 100, 50);
    pushEnd(560);
    waitRel(100);
    pause = 1'b1;
    waitRel(150);
    pause = 1'b0;
    waitDrain("pause");

    $display("[TB] stop with start in entry 1, then replay");
    applyStimulus(1'b1, 1'b0);
    pushStart();
    pushPass(0, 260, 0, 0);
    pushEv(K_BUSY, 0, 261);
    pushEv(K_BEEP, 0, 261);
    waitRel(260);
    applyStimulus(1'b1, 1'b1);
    waitDrain("stop");
    applyStimulus(1'b1, 1'b0);
    pushStart();
    pushPass(0, 100000, 0, 0);
    pushEnd(510);
    waitDrain("replay");

    $display("[TB] reset mid-note");
    applyStimulus(1'b1, 1'b0);
    pushStart();
    pushPass(0, 100, 0, 0);
    pushEv(K_BUSY, 0, 100);
    pushEv(K_BEEP, 0, 100);
    waitRel(100);
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("post_reset_busy", int'(busy), 0);
    checkOutput("post_reset_beep", int'(beep), 0);
    checkOutput("post_reset_rom_addr", int'(romAddr), 0);
    waitDrain("reset");
    applyStimulus(1'b1, 1'b0);
    pushStart();
    pushPass(0, 100000, 0, 0);
    pushEnd(510);
    waitDrain("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
